mem_arbiter: RTL

// - Memory-side responder for the pipeline's two request ports (instruction fetch, data access).
// - Serialises them onto one physical memory port with a fixed, parameterised priority.
// - Returns one-cycle registered resp pulses to the CPU control logic.
// - Sits between the CPU core and the cache/physical memory.

---
 rtl/rv32i_types.sv | 28 ++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared CPU-side type definitions; this slice carries the memory arbiter's
// FSM state and port-identity types plus the grant-selection helper.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // Fixed-priority pick between the two request ports; only meaningful
    // when at least one request is present.
    function automatic arb_port_t arb_pick(input logic d_priority,
                                           input logic inst_req,
                                           input logic data_req);
        if (data_req && (d_priority || !inst_req)) begin
            return PORT_D;
        end
        return PORT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data requests onto one memory port with
// fixed priority; every output is a flop so resp never loops back to the core.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_read,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_resp,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_mbe,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_addr,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [DATA_W/8-1:0] pmem_mbe,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp,
    output mem_arb_state_t      state_dbg
);

    localparam int MBE_W = DATA_W / 8;

    // Handshake: a port's request (and address) must stay stable from grant
    // until its resp pulse; pmem_read/pmem_write stay high with constant
    // addr/wdata/mbe until the single-cycle pmem_resp.

    mem_arb_state_t    state_q, state_d;
    arb_port_t         port_q, port_d;
    logic              abort_q, abort_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
    logic [DATA_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [MBE_W-1:0]  pmem_mbe_q, pmem_mbe_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic              inst_resp_q, inst_resp_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              data_resp_q, data_resp_d;

    logic              data_req;
    logic              granted_req;
    logic [ADDR_W-1:0] granted_addr;

    assign data_req     = data_read | data_write;
    assign granted_req  = (port_q == PORT_D) ? data_req  : inst_read;
    assign granted_addr = (port_q == PORT_D) ? data_addr : inst_addr;

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        abort_d      = abort_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        pmem_mbe_d   = pmem_mbe_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_resp_d  = 1'b0;
        data_resp_d  = 1'b0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (data_req || inst_read) begin
                    port_d = arb_pick(D_PRIORITY, inst_read, data_req);
                    if (port_d == PORT_D) begin
                        // A simultaneous read+write is treated as a write.
                        state_d      = D_BUSY;
                        pmem_write_d = data_write;
                        pmem_read_d  = !data_write;
                        pmem_addr_d  = data_addr;
                        pmem_wdata_d = data_wdata;
                        pmem_mbe_d   = data_write ? data_mbe : {MBE_W{1'b1}};
                    end else begin
                        state_d      = I_BUSY;
                        pmem_write_d = 1'b0;
                        pmem_read_d  = 1'b1;
                        pmem_addr_d  = inst_addr;
                        pmem_wdata_d = '0;
                        pmem_mbe_d   = {MBE_W{1'b1}};
                    end
                end
            end

            I_BUSY, D_BUSY: begin
                if (!granted_req || (granted_addr != pmem_addr_q)) begin
                    abort_d = 1'b1;
                end
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE;
                    if (port_q == PORT_D) begin
                        data_rdata_d = pmem_write_q ? '0 : pmem_rdata;
                    end else begin
                        inst_rdata_d = pmem_rdata;
                    end
                end
            end

            DONE: begin
                // Bubble cycle: the core sees resp while we sit in IDLE next.
                inst_resp_d = !abort_q && (port_q == PORT_I);
                data_resp_d = !abort_q && (port_q == PORT_D);
                abort_d     = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            port_q       <= PORT_I;
            abort_q      <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            pmem_mbe_q   <= '0;
            inst_rdata_q <= '0;
            inst_resp_q  <= 1'b0;
            data_rdata_q <= '0;
            data_resp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            abort_q      <= abort_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            pmem_mbe_q   <= pmem_mbe_d;
            inst_rdata_q <= inst_rdata_d;
            inst_resp_q  <= inst_resp_d;
            data_rdata_q <= data_rdata_d;
            data_resp_q  <= data_resp_d;
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign inst_resp  = inst_resp_q;
    assign data_rdata = data_rdata_q;
    assign data_resp  = data_resp_q;
    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;
    assign pmem_mbe   = pmem_mbe_q;
    assign state_dbg  = state_q;

    a_no_read_and_write: assert property (
        @(posedge clk) disable iff (!rst) !(data_read && data_write)
    );

endmodule
